// File: rtl/seg_capture_pkg.sv
// Shared constants and types for the 7-segment scan capture block.
package seg_capture_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  // gfedcba patterns, active-high; index = hex value (element 0 is the rightmost entry)
  localparam logic [15:0][SEG_W-1:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    ST_SETTLE,
    ST_HELD
  } cap_state_e;

  typedef enum logic [1:0] {
    NA_NONE,
    NA_ONE,
    NA_MULTI
  } na_code_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to hex nibble lookup.
module seg7_decode
  import seg_capture_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output logic             hit_o,
  output logic [NIB_W-1:0] nibble_o
);

  always_comb begin
    hit_o    = 1'b0;
    nibble_o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg_i == SEG_HEX[i]) begin
        hit_o    = 1'b1;
        nibble_o = NIB_W'(i);
      end
    end
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Samples a scanned 7-segment bus, decodes each settled digit and
// reassembles complete frames into the displayed value.
module seg_scan_capture
  import seg_capture_pkg::*;
#(
  parameter int unsigned NR_DIGITS      = 8,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned NA_ACTIVE_LOW  = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic                   FPGA_GlobalClock,
  input  logic                   RST_n,
  input  logic [NR_DIGITS-1:0]   NA,
  input  logic [7:0]             SEG,
  input  logic                   ErrClr,
  output logic [4*NR_DIGITS-1:0] Value,
  output logic [NR_DIGITS-1:0]   DP,
  output logic                   ValueValid,
  output logic                   DigitErr,
  output logic                   SelErr
);

  localparam int unsigned IDX_W = (NR_DIGITS > 1) ? $clog2(NR_DIGITS) : 1;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned BUS_W = NR_DIGITS + 8;

  logic [NR_DIGITS-1:0] na_s1_q, na_s2_q;
  logic [7:0]           seg_s1_q, seg_s2_q;
  logic [BUS_W-1:0]     prev_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  cap_state_e           state_q, state_d;

  logic [NR_DIGITS-1:0][NIB_W-1:0] shadow_q, shadow_d;
  logic [NR_DIGITS-1:0]            dpsh_q, dpsh_d;
  logic [NR_DIGITS-1:0]            seen_q, seen_d;
  logic [NR_DIGITS-1:0][NIB_W-1:0] value_q, value_d;
  logic [NR_DIGITS-1:0]            dp_q, dp_d;
  logic                            valid_q, valid_d;
  logic                            digit_err_q, digit_err_d;
  logic                            sel_err_q, sel_err_d;

  logic [NR_DIGITS-1:0] na_norm;
  logic [7:0]           seg_norm;
  logic [BUS_W-1:0]     bus_cur;
  logic                 change;
  logic                 commit_c;
  logic                 frame_done_c;
  na_code_e             na_code;
  logic [IDX_W-1:0]     na_idx;
  logic                 dec_hit;
  logic [NIB_W-1:0]     dec_nib;

  // Two-flop synchronisers; the scanner runs on an unrelated clock
  always_ff @(posedge FPGA_GlobalClock or negedge RST_n) begin
    if (!RST_n) begin
      na_s1_q  <= '0;
      na_s2_q  <= '0;
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      prev_q   <= '0;
    end else begin
      na_s1_q  <= NA;
      na_s2_q  <= na_s1_q;
      seg_s1_q <= SEG;
      seg_s2_q <= seg_s1_q;
      prev_q   <= bus_cur;
    end
  end

  assign na_norm  = (NA_ACTIVE_LOW != 0) ? ~na_s2_q : na_s2_q;
  assign seg_norm = (SEG_ACTIVE_LOW != 0) ? ~seg_s2_q : seg_s2_q;
  assign bus_cur  = {na_norm, seg_norm};
  assign change   = (bus_cur != prev_q);

  always_ff @(posedge FPGA_GlobalClock or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_SETTLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stability FSM: exactly one commit per dwell once the bus has settled
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_c = 1'b0;
    if (change) begin
      cnt_d   = '0;
      state_d = ST_SETTLE;
    end else if (state_q == ST_SETTLE) begin
      if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
        commit_c = 1'b1;
        state_d  = ST_HELD;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    na_code = NA_NONE;
    na_idx  = '0;
    for (int i = 0; i < int'(NR_DIGITS); i++) begin
      if (na_norm[i]) begin
        na_code = (na_code == NA_NONE) ? NA_ONE : NA_MULTI;
        na_idx  = IDX_W'(i);
      end
    end
  end

  seg7_decode u_dec (
    .seg_i    (seg_norm[6:0]),
    .hit_o    (dec_hit),
    .nibble_o (dec_nib)
  );

  assign frame_done_c = &seen_q;

  // Shadow/seen bookkeeping, frame publication and sticky error flags
  always_comb begin
    shadow_d    = shadow_q;
    dpsh_d      = dpsh_q;
    seen_d      = frame_done_c ? '0 : seen_q;
    value_d     = value_q;
    dp_d        = dp_q;
    valid_d     = 1'b0;
    digit_err_d = digit_err_q & ~ErrClr;
    sel_err_d   = sel_err_q & ~ErrClr;
    if (frame_done_c) begin
      value_d = shadow_q;
      dp_d    = dpsh_q;
      valid_d = 1'b1;
    end
    if (commit_c) begin
      case (na_code)
        NA_ONE: begin
          if (dec_hit) begin
            shadow_d[na_idx] = dec_nib;
            dpsh_d[na_idx]   = seg_norm[7];
            seen_d[na_idx]   = 1'b1;
          end else begin
            digit_err_d = 1'b1;
          end
        end
        NA_MULTI: sel_err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge FPGA_GlobalClock or negedge RST_n) begin
    if (!RST_n) begin
      shadow_q    <= '0;
      dpsh_q      <= '0;
      seen_q      <= '0;
      value_q     <= '0;
      dp_q        <= '0;
      valid_q     <= 1'b0;
      digit_err_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      dpsh_q      <= dpsh_d;
      seen_q      <= seen_d;
      value_q     <= value_d;
      dp_q        <= dp_d;
      valid_q     <= valid_d;
      digit_err_q <= digit_err_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign Value      = value_q;
  assign DP         = dp_q;
  assign ValueValid = valid_q;
  assign DigitErr   = digit_err_q;
  assign SelErr     = sel_err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: directed scans, queued expected frames.
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  na = 8'hFF;
  logic [7:0]  seg = 8'hFF;
  logic        err_clr = 1'b0;
  logic [31:0] value;
  logic [7:0]  dp;
  logic        value_valid;
  logic        digit_err;
  logic        sel_err;

  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  dp;
  } frame_t;

  frame_t exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  // gfedcba, active-high, hand-entered
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  seg_scan_capture dut (
    .FPGA_GlobalClock (clk),
    .RST_n            (rst_n),
    .NA               (na),
    .SEG              (seg),
    .ErrClr           (err_clr),
    .Value            (value),
    .DP               (dp),
    .ValueValid       (value_valid),
    .DigitErr         (digit_err),
    .SelErr           (sel_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every ValueValid pulse must match the oldest queued frame
  always @(negedge clk) begin
    if (rst_n && value_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got Value=%h DP=%h, required no pulse", value, dp);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        check("frame_value", value, e.value);
        check("frame_dp", 32'(dp), 32'(e.dp));
      end
    end
  end

  task automatic drive_raw(input logic [7:0] na_raw, input logic [7:0] seg_raw, input int dwell);
    @(posedge clk);
    #1;
    na  = na_raw;
    seg = seg_raw;
    repeat (dwell - 1) @(posedge clk);
  endtask

  task automatic show(input int d, input logic [3:0] nib, input logic dpl, input int dwell);
    logic [7:0] n;
    n = 8'hFF;
    n[d] = 1'b0;
    drive_raw(n, ~{dpl, hex_tab[nib]}, dwell);
  endtask

  task automatic blank(input int dwell);
    drive_raw(8'hFF, 8'hFF, dwell);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
  endtask

  task automatic scan_frame(input logic [31:0] v, input logic [7:0] dps, input bit descending);
    for (int k = 0; k < 8; k++) begin
      int d;
      d = descending ? 7 - k : k;
      show(d, v[4*d +: 4], dps[d], 20);
    end
  endtask

  initial begin
    logic [31:0] v;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", value, 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_valid", 32'(value_valid), 32'h0);
    check("rst_digit_err", 32'(digit_err), 32'h0);
    check("rst_sel_err", 32'(sel_err), 32'h0);
    rst_n = 1'b1;
    blank(10);

    // T1: plain frame, ascending scan
    exp_q.push_back('{value: 32'h1234ABCD, dp: 8'h00});
    scan_frame(32'h1234ABCD, 8'h00, 1'b0);
    blank(10);

    // T2: 3-cycle dwell on digit 2 must not commit
    v = 32'h76543210;
    for (int d = 0; d < 8; d++) begin
      if (d == 2) show(2, 4'hE, 1'b0, 3);
      else        show(d, v[4*d +: 4], 1'b0, 20);
    end
    blank(10);
    exp_q.push_back('{value: 32'h76543210, dp: 8'h00});
    show(2, 4'h2, 1'b0, 20);
    blank(10);

    // T3: two anodes active at once
    drive_raw(8'b1111_0011, ~{1'b0, hex_tab[4'h5]}, 10);
    #1;
    check("t3_sel_err_set", 32'(sel_err), 32'h1);
    check("t3_digit_err_clear", 32'(digit_err), 32'h0);
    blank(5);
    pulse_clr();
    #1;
    check("t3_sel_err_cleared", 32'(sel_err), 32'h0);

    // T4: undecodable pattern on digit 5, then re-scanned as F
    v = 32'hCAFEF00D;
    for (int k = 0; k < 6; k++) begin
      int d;
      d = (k < 3) ? k : k + 1 + ((k >= 4) ? 1 : 0);
      show(d, v[4*d +: 4], 1'b0, 20);
    end
    drive_raw(8'b1101_1111, ~8'h49, 20);
    #1;
    check("t4_digit_err_set", 32'(digit_err), 32'h1);
    show(5, 4'hF, 1'b0, 20);
    exp_q.push_back('{value: 32'hCAFEF00D, dp: 8'h00});
    show(3, 4'hF, 1'b0, 20);
    blank(10);
    pulse_clr();
    #1;
    check("t4_digit_err_cleared", 32'(digit_err), 32'h0);

    // T5: descending scan twice with DP on digit 3
    exp_q.push_back('{value: 32'hDEADBEEF, dp: 8'h08});
    exp_q.push_back('{value: 32'hDEADBEEF, dp: 8'h08});
    scan_frame(32'hDEADBEEF, 8'h08, 1'b1);
    scan_frame(32'hDEADBEEF, 8'h08, 1'b1);
    blank(10);

    // T6: reset mid-frame discards the partial frame
    v = 32'h77777777;
    for (int d = 0; d < 5; d++) show(d, v[4*d +: 4], 1'b1, 20);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_value_in_reset", value, 32'h0);
    check("t6_dp_in_reset", 32'(dp), 32'h0);
    blank(5);
    rst_n = 1'b1;
    blank(10);
    exp_q.push_back('{value: 32'h00000001, dp: 8'h00});
    scan_frame(32'h00000001, 8'h00, 1'b1);
    blank(10);
    #1;
    check("t6_final_value", value, 32'h00000001);

    check("frames_pending", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
